// File: rtl/dmu_sii_pkg.sv
// Shared types and header field offsets for the DMU->SII inbound packet tracker.
package dmu_sii_pkg;

  typedef enum logic [1:0] {
    DMA_RD  = 2'd0,
    DMA_WR  = 2'd1,
    MONDO   = 2'd2,
    PIO_RET = 2'd3
  } pkt_type_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WR_PAY = 2'd1,
    MD_PAY = 2'd2
  } state_e;

  localparam int TAG_LSB = 64;
  localparam int TAG_W   = 16;
  localparam int PA_W    = 40;

  // The illegal (!datareq && datareq16) combination is screened separately by the caller.
  function automatic pkt_type_e classify(input logic datareq, input logic datareq16,
                                         input logic reqbypass);
    if (!datareq)        return DMA_RD;
    else if (!datareq16) return DMA_WR;
    else if (reqbypass)  return PIO_RET;
    else                 return MONDO;
  endfunction

endpackage

// File: rtl/dmu_sii_par_chk.sv
// Even-parity compare: one parity bit per PAR_GRP data bits, any group mismatch flags.
module dmu_sii_par_chk #(
  parameter int DATA_W  = 128,
  parameter int PAR_GRP = 16
) (
  input  logic [DATA_W-1:0]         data,
  input  logic [DATA_W/PAR_GRP-1:0] parity,
  output logic                      mismatch
);

  logic [DATA_W/PAR_GRP-1:0] calc;

  always_comb begin
    calc = '0;
    for (int i = 0; i < DATA_W / PAR_GRP; i++) begin
      calc[i] = ^data[i*PAR_GRP +: PAR_GRP];
    end
  end

  assign mismatch = |(calc ^ parity);

endmodule

// File: rtl/dmu_sii_pkt_tracker.sv
// Inbound dmu_sii_* monitor: classifies headers, counts payload beats, checks parity,
// tracks DMA-write credits against sii_dmu_wrack and keeps saturating statistics.
module dmu_sii_pkt_tracker
  import dmu_sii_pkg::*;
#(
  parameter int DATA_W      = 128,
  parameter int PAR_GRP     = 16,
  parameter int WR_BEATS    = 4,
  parameter int MD_BEATS    = 1,
  parameter int MAX_WR_CRED = 16,
  parameter int CNT_W       = 16,
  localparam int PAR_W      = DATA_W / PAR_GRP,
  localparam int CRED_W     = $clog2(MAX_WR_CRED + 1)
) (
  input  logic              iol2clk,
  input  logic              rst,
  input  logic              dmu_sii_hdr_vld,
  input  logic              dmu_sii_reqbypass,
  input  logic              dmu_sii_datareq,
  input  logic              dmu_sii_datareq16,
  input  logic [DATA_W-1:0] dmu_sii_data,
  input  logic [PAR_W-1:0]  dmu_sii_parity,
  input  logic              sii_dmu_wrack_vld,
  output logic              pkt_done,
  output logic [1:0]        pkt_type,
  output logic [15:0]       pkt_tag,
  output logic [39:0]       pkt_pa,
  output logic              par_err,
  output logic              proto_err,
  output logic [CRED_W-1:0] wr_outstanding,
  output logic [CNT_W-1:0]  cnt_rd,
  output logic [CNT_W-1:0]  cnt_wr,
  output logic [CNT_W-1:0]  cnt_md,
  output logic [CNT_W-1:0]  cnt_pio,
  output logic [CNT_W-1:0]  cnt_par_err,
  output logic [1:0]        dbg_state
);

  // Handshake: dmu_sii_hdr_vld qualifies a header cycle and there is no ready; the tracker
  // always accepts. Every cycle after a header is a payload beat until the packet's beat
  // count is reached; a header arriving inside that window aborts the packet in flight.

  localparam int MAX_BEATS = (WR_BEATS > MD_BEATS) ? WR_BEATS : MD_BEATS;
  localparam int BEAT_W    = $clog2(MAX_BEATS + 1);

  state_e            state_q, state_d;
  logic [BEAT_W-1:0] beat_q, beat_d, last_idx;
  pkt_type_e         hdr_cls, type_q, done_type;
  logic              hdr_illegal, hdr_ok, is_beat, done_d, proto_fsm;
  logic              par_mismatch, check_par;
  logic              wr_hdr, cred_err;
  logic [CRED_W-1:0] cred_d;
  logic [TAG_W-1:0]  tag_q;
  logic [PA_W-1:0]   pa_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  dmu_sii_par_chk #(
    .DATA_W  (DATA_W),
    .PAR_GRP (PAR_GRP)
  ) u_par_chk (
    .data     (dmu_sii_data),
    .parity   (dmu_sii_parity),
    .mismatch (par_mismatch)
  );

  assign hdr_illegal = !dmu_sii_datareq && dmu_sii_datareq16;
  assign hdr_ok      = dmu_sii_hdr_vld && !hdr_illegal;
  assign hdr_cls     = classify(dmu_sii_datareq, dmu_sii_datareq16, dmu_sii_reqbypass);
  assign last_idx    = (state_q == WR_PAY) ? BEAT_W'(WR_BEATS - 1) : BEAT_W'(MD_BEATS - 1);
  assign check_par   = dmu_sii_hdr_vld || is_beat;
  assign wr_hdr      = hdr_ok && (hdr_cls == DMA_WR);

  always_ff @(posedge iol2clk) begin
    if (rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    done_d    = 1'b0;
    proto_fsm = 1'b0;
    is_beat   = 1'b0;
    done_type = type_q;
    if (dmu_sii_hdr_vld) begin
      beat_d    = '0;
      state_d   = IDLE;
      proto_fsm = hdr_illegal || (state_q != IDLE);
      if (!hdr_illegal) begin
        case (hdr_cls)
          DMA_RD: begin
            done_d    = 1'b1;
            done_type = DMA_RD;
          end
          DMA_WR:  state_d = WR_PAY;
          default: state_d = MD_PAY;
        endcase
      end
    end else if (state_q != IDLE) begin
      is_beat = 1'b1;
      if (beat_q == last_idx) begin
        done_d  = 1'b1;
        state_d = IDLE;
        beat_d  = '0;
      end else begin
        beat_d = beat_q + 1'b1;
      end
    end
  end

  // A write header and a wrack in the same cycle cancel; either alone at its limit is an error.
  always_comb begin
    cred_d   = wr_outstanding;
    cred_err = 1'b0;
    if (wr_hdr && !sii_dmu_wrack_vld) begin
      if (wr_outstanding == CRED_W'(MAX_WR_CRED)) cred_err = 1'b1;
      else                                        cred_d   = wr_outstanding + 1'b1;
    end else if (!wr_hdr && sii_dmu_wrack_vld) begin
      if (wr_outstanding == '0) cred_err = 1'b1;
      else                      cred_d   = wr_outstanding - 1'b1;
    end
  end

  always_ff @(posedge iol2clk) begin
    if (rst) begin
      pkt_done       <= 1'b0;
      par_err        <= 1'b0;
      proto_err      <= 1'b0;
      wr_outstanding <= '0;
      type_q         <= DMA_RD;
      tag_q          <= '0;
      pa_q           <= '0;
      cnt_rd         <= '0;
      cnt_wr         <= '0;
      cnt_md         <= '0;
      cnt_pio        <= '0;
      cnt_par_err    <= '0;
    end else begin
      pkt_done       <= done_d;
      par_err        <= check_par && par_mismatch;
      proto_err      <= proto_fsm || cred_err;
      wr_outstanding <= cred_d;
      if (hdr_ok) begin
        type_q <= hdr_cls;
        tag_q  <= dmu_sii_data[TAG_LSB +: TAG_W];
        pa_q   <= dmu_sii_data[PA_W-1:0];
      end
      if (check_par && par_mismatch) cnt_par_err <= sat_inc(cnt_par_err);
      if (done_d) begin
        case (done_type)
          DMA_RD:  cnt_rd  <= sat_inc(cnt_rd);
          DMA_WR:  cnt_wr  <= sat_inc(cnt_wr);
          MONDO:   cnt_md  <= sat_inc(cnt_md);
          default: cnt_pio <= sat_inc(cnt_pio);
        endcase
      end
    end
  end

  assign pkt_type  = type_q;
  assign pkt_tag   = tag_q;
  assign pkt_pa    = pa_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_dmu_sii_pkt_tracker.sv
// Bench for dmu_sii_pkt_tracker: vector table, directed corner sequences, random traffic vs model.
module tb_dmu_sii_pkt_tracker;

  localparam int DATA_W   = 128;
  localparam int PAR_GRP  = 16;
  localparam int PAR_W    = DATA_W / PAR_GRP;
  localparam int WR_BEATS = 4;
  localparam int MD_BEATS = 1;
  localparam int MAX_CRED = 16;
  localparam int CNT_W    = 4;
  localparam int CRED_W   = $clog2(MAX_CRED + 1);

  logic              iol2clk = 1'b0;
  logic              rst, hdr_vld, reqbypass, datareq, datareq16, wrack;
  logic [DATA_W-1:0] data;
  logic [PAR_W-1:0]  parity;
  logic              pkt_done, par_err, proto_err;
  logic [1:0]        pkt_type, dbg_state;
  logic [15:0]       pkt_tag;
  logic [39:0]       pkt_pa;
  logic [CRED_W-1:0] wr_outstanding;
  logic [CNT_W-1:0]  cnt_rd, cnt_wr, cnt_md, cnt_pio, cnt_par_err;

  int n_checks = 0;
  int n_fail   = 0;

  dmu_sii_pkt_tracker #(
    .DATA_W(DATA_W), .PAR_GRP(PAR_GRP), .WR_BEATS(WR_BEATS), .MD_BEATS(MD_BEATS),
    .MAX_WR_CRED(MAX_CRED), .CNT_W(CNT_W)
  ) dut (
    .iol2clk(iol2clk), .rst(rst), .dmu_sii_hdr_vld(hdr_vld), .dmu_sii_reqbypass(reqbypass),
    .dmu_sii_datareq(datareq), .dmu_sii_datareq16(datareq16), .dmu_sii_data(data),
    .dmu_sii_parity(parity), .sii_dmu_wrack_vld(wrack), .pkt_done(pkt_done),
    .pkt_type(pkt_type), .pkt_tag(pkt_tag), .pkt_pa(pkt_pa), .par_err(par_err),
    .proto_err(proto_err), .wr_outstanding(wr_outstanding), .cnt_rd(cnt_rd),
    .cnt_wr(cnt_wr), .cnt_md(cnt_md), .cnt_pio(cnt_pio), .cnt_par_err(cnt_par_err),
    .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 iol2clk = ~iol2clk;

  // ---------------- reference model ----------------
  int         m_left;
  logic [1:0] m_type;
  logic [15:0] m_tag;
  logic [39:0] m_pa;
  int         m_cred;
  int         m_cnt[4];
  int         m_cnt_par;
  logic       e_done, e_par, e_proto;

  function automatic logic [PAR_W-1:0] good_par(input logic [DATA_W-1:0] d);
    logic [PAR_W-1:0] p;
    for (int g = 0; g < PAR_W; g++) begin
      p[g] = 1'b0;
      for (int b = 0; b < PAR_GRP; b++) p[g] = p[g] ^ d[g*PAR_GRP + b];
    end
    return p;
  endfunction

  function automatic int sat(input int v);
    return (v >= (1 << CNT_W) - 1) ? v : v + 1;
  endfunction

  task automatic model_step();
    logic [1:0] cls;
    logic wr_hdr;
    wr_hdr = 1'b0;
    e_done = 1'b0; e_par = 1'b0; e_proto = 1'b0;
    if (rst) begin
      m_left = 0; m_type = 2'd0; m_tag = '0; m_pa = '0; m_cred = 0; m_cnt_par = 0;
      foreach (m_cnt[i]) m_cnt[i] = 0;
      return;
    end
    if ((hdr_vld || m_left > 0) && (parity != good_par(data))) begin
      e_par = 1'b1;
      m_cnt_par = sat(m_cnt_par);
    end
    if (hdr_vld) begin
      if (m_left > 0) e_proto = 1'b1;
      m_left = 0;
      if (!datareq && datareq16) begin
        e_proto = 1'b1;
      end else begin
        cls = !datareq ? 2'd0 : (!datareq16 ? 2'd1 : (reqbypass ? 2'd3 : 2'd2));
        m_type = cls; m_tag = data[79:64]; m_pa = data[39:0];
        if (cls == 2'd0) begin
          e_done = 1'b1;
          m_cnt[0] = sat(m_cnt[0]);
        end else begin
          m_left = (cls == 2'd1) ? WR_BEATS : MD_BEATS;
        end
        wr_hdr = (cls == 2'd1);
      end
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        e_done = 1'b1;
        m_cnt[m_type] = sat(m_cnt[m_type]);
      end
    end
    if (wr_hdr && !wrack) begin
      if (m_cred == MAX_CRED) e_proto = 1'b1;
      else m_cred++;
    end else if (wrack && !wr_hdr) begin
      if (m_cred == 0) e_proto = 1'b1;
      else m_cred--;
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_check();
    chk("m_done", pkt_done, e_done);
    chk("m_par_err", par_err, e_par);
    chk("m_proto_err", proto_err, e_proto);
    chk("m_wr_out", wr_outstanding, m_cred);
    chk("m_cnt_rd", cnt_rd, m_cnt[0]);
    chk("m_cnt_wr", cnt_wr, m_cnt[1]);
    chk("m_cnt_md", cnt_md, m_cnt[2]);
    chk("m_cnt_pio", cnt_pio, m_cnt[3]);
    chk("m_cnt_par", cnt_par_err, m_cnt_par);
    if (e_done) begin
      chk("m_type", pkt_type, m_type);
      chk("m_tag", pkt_tag, m_tag);
      chk("m_pa", pkt_pa, m_pa);
    end
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_done"}, pkt_done, 0);
    chk({nm, "_type"}, pkt_type, 0);
    chk({nm, "_tag"}, pkt_tag, 0);
    chk({nm, "_pa"}, pkt_pa, 0);
    chk({nm, "_par"}, par_err, 0);
    chk({nm, "_proto"}, proto_err, 0);
    chk({nm, "_wr_out"}, wr_outstanding, 0);
    chk({nm, "_cnt_rd"}, cnt_rd, 0);
    chk({nm, "_cnt_wr"}, cnt_wr, 0);
    chk({nm, "_cnt_md"}, cnt_md, 0);
    chk({nm, "_cnt_pio"}, cnt_pio, 0);
    chk({nm, "_cnt_par"}, cnt_par_err, 0);
    chk({nm, "_state"}, dbg_state, 0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    model_step();
    @(posedge iol2clk);
    #1;
    model_check();
  endtask

  function automatic logic [DATA_W-1:0] rand_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic set_idle();
    hdr_vld = 1'b0; datareq = 1'b0; datareq16 = 1'b0; reqbypass = 1'b0;
    data = rand_data();
    parity = PAR_W'($urandom);
  endtask

  task automatic set_hdr(input logic dr, input logic dr16, input logic byp,
                         input logic [15:0] tag, input logic [39:0] pa);
    hdr_vld = 1'b1; datareq = dr; datareq16 = dr16; reqbypass = byp;
    data = rand_data();
    data[79:64] = tag;
    data[39:0] = pa;
    parity = good_par(data);
  endtask

  task automatic set_beat(input int flip);
    hdr_vld = 1'b0; datareq = 1'b0; datareq16 = 1'b0; reqbypass = 1'b0;
    data = rand_data();
    parity = good_par(data);
    if (flip >= 0) data[flip] = ~data[flip];
  endtask

  task automatic do_reset();
    rst = 1'b1; wrack = 1'b0;
    set_idle();
    tick();
    tick();
    rst = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       dr;
    logic       dr16;
    logic       byp;
    int         beats;
    logic       exp_proto;
    logic       exp_done;
    logic [1:0] exp_type;
  } vec_t;

  vec_t vecs[7];

  initial begin
    rst = 1'b1; wrack = 1'b0;
    set_idle();
    vecs[0] = '{1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1, 2'd0};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 4, 1'b0, 1'b1, 2'd1};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 1, 1'b0, 1'b1, 2'd2};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 1, 1'b0, 1'b1, 2'd3};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 0, 1'b1, 1'b0, 2'd0};
    vecs[5] = '{1'b0, 1'b1, 1'b1, 0, 1'b1, 1'b0, 2'd0};
    vecs[6] = '{1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b1, 2'd0};

    tick();
    chk_all_zero("reset");
    rst = 1'b0;

    // Table-driven classification.
    do_reset();
    for (int i = 0; i < 7; i++) begin
      set_hdr(vecs[i].dr, vecs[i].dr16, vecs[i].byp, 16'(16'h0100 + i), 40'(i));
      tick();
      chk("tbl_proto", proto_err, vecs[i].exp_proto);
      for (int b = 0; b < vecs[i].beats; b++) begin
        set_beat(-1);
        tick();
      end
      chk("tbl_done", pkt_done, vecs[i].exp_done);
      if (vecs[i].exp_done) chk("tbl_type", pkt_type, vecs[i].exp_type);
      set_idle();
      wrack = vecs[i].exp_done && (vecs[i].exp_type == 2'd1);
      tick();
      wrack = 1'b0;
    end

    // Read.
    do_reset();
    set_hdr(1'b0, 1'b0, 1'b0, 16'h00A5, 40'h12_3456_7890);
    tick();
    chk("rd_done", pkt_done, 1);
    chk("rd_type", pkt_type, 0);
    chk("rd_tag", pkt_tag, 16'h00A5);
    chk("rd_pa", pkt_pa, 40'h12_3456_7890);
    chk("rd_cnt", cnt_rd, 1);
    set_idle();
    tick();
    chk("rd_done_clr", pkt_done, 0);

    // Write, then credit return three cycles later.
    do_reset();
    set_hdr(1'b1, 1'b0, 1'b0, 16'h0BEE, 40'hAB_CDEF_0123);
    tick();
    chk("wr_out_hdr", wr_outstanding, 1);
    for (int b = 0; b < WR_BEATS; b++) begin
      set_beat(-1);
      tick();
      chk("wr_done_beat", pkt_done, b == WR_BEATS - 1);
    end
    chk("wr_type", pkt_type, 1);
    chk("wr_tag", pkt_tag, 16'h0BEE);
    chk("wr_cnt", cnt_wr, 1);
    set_idle();
    tick();
    tick();
    wrack = 1'b1;
    tick();
    wrack = 1'b0;
    chk("wrack_out", wr_outstanding, 0);
    chk("wrack_proto", proto_err, 0);

    // Mondo then PIO return, back to back.
    do_reset();
    set_hdr(1'b1, 1'b1, 1'b0, 16'h1111, 40'h1);
    tick();
    set_beat(-1);
    tick();
    chk("md_done", pkt_done, 1);
    chk("md_type", pkt_type, 2);
    set_hdr(1'b1, 1'b1, 1'b1, 16'h2222, 40'h2);
    tick();
    chk("pio_hdr_done", pkt_done, 0);
    set_beat(-1);
    tick();
    chk("pio_done", pkt_done, 1);
    chk("pio_type", pkt_type, 3);
    chk("pio_tag", pkt_tag, 16'h2222);
    chk("md_cnt", cnt_md, 1);
    chk("pio_cnt", cnt_pio, 1);

    // Parity error on beat 2 of a write.
    do_reset();
    set_hdr(1'b1, 1'b0, 1'b0, 16'h0033, 40'h33);
    tick();
    set_beat(-1);
    tick();
    chk("par_b1", par_err, 0);
    set_beat(17);
    tick();
    chk("par_b2", par_err, 1);
    chk("par_cnt", cnt_par_err, 1);
    set_beat(-1);
    tick();
    chk("par_b3", par_err, 0);
    set_beat(-1);
    tick();
    chk("par_done", pkt_done, 1);
    chk("par_cnt_end", cnt_par_err, 1);
    chk("par_cnt_wr", cnt_wr, 1);

    // Read header on beat 2 aborts the write.
    do_reset();
    set_hdr(1'b1, 1'b0, 1'b0, 16'h0303, 40'h303);
    tick();
    set_beat(-1);
    tick();
    set_hdr(1'b0, 1'b0, 1'b0, 16'h0404, 40'h404);
    tick();
    chk("abort_proto", proto_err, 1);
    chk("abort_rd_done", pkt_done, 1);
    chk("abort_rd_type", pkt_type, 0);
    chk("abort_rd_tag", pkt_tag, 16'h0404);
    chk("abort_cnt_rd", cnt_rd, 1);
    set_idle();
    repeat (5) tick();
    chk("abort_cnt_wr", cnt_wr, 0);
    chk("abort_wr_out", wr_outstanding, 1);

    // Credit limits.
    do_reset();
    wrack = 1'b1;
    set_idle();
    tick();
    wrack = 1'b0;
    chk("cred_under_proto", proto_err, 1);
    chk("cred_under_out", wr_outstanding, 0);
    for (int w = 0; w < MAX_CRED; w++) begin
      set_hdr(1'b1, 1'b0, 1'b0, 16'(w), 40'(w));
      tick();
      for (int b = 0; b < WR_BEATS; b++) begin
        set_beat(-1);
        tick();
      end
    end
    chk("cred_full_out", wr_outstanding, MAX_CRED);
    set_hdr(1'b1, 1'b0, 1'b0, 16'h0017, 40'h17);
    tick();
    chk("cred_over_proto", proto_err, 1);
    chk("cred_over_out", wr_outstanding, MAX_CRED);
    for (int b = 0; b < WR_BEATS; b++) begin
      set_beat(-1);
      tick();
    end
    set_hdr(1'b1, 1'b0, 1'b0, 16'h0018, 40'h18);
    wrack = 1'b1;
    tick();
    wrack = 1'b0;
    chk("cred_both_proto", proto_err, 0);
    chk("cred_both_out", wr_outstanding, MAX_CRED);
    chk("cnt_wr_sat", cnt_wr, (1 << CNT_W) - 1);
    set_beat(-1);
    tick();
    rst = 1'b1;
    set_beat(-1);
    tick();
    chk_all_zero("midrst");
    rst = 1'b0;

    // Random traffic against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 499) == 0);
      wrack = ($urandom_range(0, 3) == 0);
      if (m_left > 0 && $urandom_range(0, 19) != 0) begin
        set_beat(-1);
      end else if ($urandom_range(0, 2) != 0) begin
        logic dr, dr16;
        dr = 1'($urandom_range(0, 1));
        dr16 = 1'($urandom_range(0, 1));
        if (!dr && dr16 && $urandom_range(0, 3) != 0) dr16 = 1'b0;
        set_hdr(dr, dr16, 1'($urandom_range(0, 1)), 16'($urandom), 40'({$urandom, $urandom}));
      end else begin
        set_idle();
      end
      if ((hdr_vld || m_left > 0) && $urandom_range(0, 15) == 0) begin
        int fb;
        fb = $urandom_range(0, DATA_W - 1);
        data[fb] = ~data[fb];
      end
      tick();
    end
    rst = 1'b0;
    wrack = 1'b0;
    set_idle();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
